// File: rtl/fft_frame_ctrl.sv
// Frame controller for a run-time-configurable streaming FFT core: issues the
// per-frame config beat, gates N input samples with tlast, and unpacks results.
module fft_frame_ctrl #(
   parameter int SAMPLE_W = 16,
   parameter int OUT_W    = 32,
   parameter int MAX_LOG2 = 10,
   parameter int MIN_LOG2 = 3,
   parameter int CFG_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  inv,
   input  logic [4:0]            nfft_log2,
   input  logic                  err_clr,
   output logic                  busy,
   output logic                  frame_done,
   output logic [3:0]            err,
   input  logic [2*SAMPLE_W-1:0] in_tdata,
   input  logic                  in_tvalid,
   output logic                  in_tready,
   output logic [CFG_W-1:0]      cfg_tdata,
   output logic                  cfg_tvalid,
   input  logic                  cfg_tready,
   output logic [2*SAMPLE_W-1:0] core_in_tdata,
   output logic                  core_in_tvalid,
   input  logic                  core_in_tready,
   output logic                  core_in_tlast,
   input  logic [2*OUT_W-1:0]    core_out_tdata,
   input  logic                  core_out_tvalid,
   output logic                  core_out_tready,
   input  logic                  core_out_tlast,
   input  logic                  ev_tlast_unexpected,
   input  logic                  ev_tlast_missing,
   output logic [OUT_W-1:0]      out_re,
   output logic [OUT_W-1:0]      out_im,
   output logic [MAX_LOG2-1:0]   out_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [1:0]            dbg_state
);

   // All streams use valid/ready: a beat transfers on a rising edge where both
   // are high; a source holds data stable while valid is high and ready is low.
   typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_STREAM, ST_DRAIN} state_t;

   localparam logic [MAX_LOG2-1:0] CNT_ONE = MAX_LOG2'(1);

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                cfg_tvalid_q, cfg_tvalid_d;
   logic [CFG_W-1:0]    cfg_tdata_q, cfg_tdata_d;
   logic [CFG_W-1:0]    last_cfg_q, last_cfg_d;
   logic                cfg_sent_q, cfg_sent_d;
   logic [3:0]          err_q, err_d;
   logic [MAX_LOG2-1:0] in_cnt_q, in_cnt_d;
   logic [MAX_LOG2-1:0] out_cnt_q, out_cnt_d;
   logic [MAX_LOG2-1:0] nm1_q, nm1_d;

   logic                legal_len;
   logic [CFG_W-1:0]    new_cfg;
   logic [MAX_LOG2:0]   n_full;
   logic [MAX_LOG2-1:0] new_nm1;
   logic                in_stream, in_hs, out_hs, in_last, out_at_end;

   assign legal_len  = (nfft_log2 >= 5'(MIN_LOG2)) && (nfft_log2 <= 5'(MAX_LOG2));
   assign n_full     = (MAX_LOG2+1)'(1) << nfft_log2;
   assign new_nm1    = MAX_LOG2'(n_full - (MAX_LOG2+1)'(1));
   assign in_stream  = (state_q == ST_STREAM);
   assign in_hs      = in_stream && in_tvalid && core_in_tready;
   assign out_hs     = core_out_tvalid && out_ready;
   assign in_last    = (in_cnt_q == nm1_q);
   assign out_at_end = (out_cnt_q == nm1_q);

   // Core expects 1 in bit 8 for a forward transform.
   always_comb begin
      new_cfg    = '0;
      new_cfg[4:0] = nfft_log2;
      new_cfg[8] = ~inv;
   end

   assign core_in_tdata   = in_tdata;
   assign core_in_tvalid  = in_stream && in_tvalid;
   assign in_tready       = in_stream && core_in_tready;
   assign core_in_tlast   = in_stream && in_last;
   assign out_re          = core_out_tdata[OUT_W-1:0];
   assign out_im          = core_out_tdata[2*OUT_W-1:OUT_W];
   assign out_valid       = core_out_tvalid;
   assign core_out_tready = out_ready;
   assign out_last        = core_out_tlast;
   assign out_idx         = out_cnt_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign cfg_tvalid      = cfg_tvalid_q;
   assign cfg_tdata       = cfg_tdata_q;
   assign err             = err_q;
   assign dbg_state       = state_q;

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      cfg_tvalid_d = cfg_tvalid_q;
      cfg_tdata_d  = cfg_tdata_q;
      last_cfg_d   = last_cfg_q;
      cfg_sent_d   = cfg_sent_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      nm1_d        = nm1_q;
      // Clear first, then set: a coincident error keeps its bit.
      err_d        = err_clr ? 4'b0000 : err_q;
      if (ev_tlast_unexpected) err_d[1] = 1'b1;
      if (ev_tlast_missing)    err_d[2] = 1'b1;

      if (out_hs) begin
         out_cnt_d = core_out_tlast ? '0 : out_cnt_q + CNT_ONE;
         if (core_out_tlast != out_at_end) err_d[3] = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (legal_len) begin
                  nm1_d        = new_nm1;
                  cfg_tdata_d  = new_cfg;
                  busy_d       = 1'b1;
                  in_cnt_d     = '0;
                  // An unchanged configuration already loaded in the core is not resent.
                  cfg_tvalid_d = !(cfg_sent_q && (new_cfg == last_cfg_q));
                  state_d      = ST_CFG;
               end else begin
                  err_d[0] = 1'b1;
               end
            end
         end
         ST_CFG: begin
            if (!cfg_tvalid_q) begin
               state_d = ST_STREAM;
            end else if (cfg_tready) begin
               cfg_tvalid_d = 1'b0;
               cfg_sent_d   = 1'b1;
               last_cfg_d   = cfg_tdata_q;
               state_d      = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (in_hs) begin
               if (in_last) begin
                  in_cnt_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_ONE;
               end
            end
         end
         ST_DRAIN: begin
            if (out_hs && core_out_tlast) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_tvalid_q <= 1'b0;
         cfg_tdata_q  <= '0;
         last_cfg_q   <= '0;
         cfg_sent_q   <= 1'b0;
         err_q        <= 4'b0000;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         nm1_q        <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         cfg_tvalid_q <= cfg_tvalid_d;
         cfg_tdata_q  <= cfg_tdata_d;
         last_cfg_q   <= last_cfg_d;
         cfg_sent_q   <= cfg_sent_d;
         err_q        <= err_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         nm1_q        <= nm1_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: start/length table, full frames with
// backpressure, config skipping, error flags and mid-frame reset.
module tb_fft_frame_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0, S_CFG = 2'd1, S_STREAM = 2'd2, S_DRAIN = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, inv, err_clr;
   logic [4:0]  nfft_log2;
   logic        busy, frame_done;
   logic [3:0]  err;
   logic [31:0] in_tdata;
   logic        in_tvalid, in_tready;
   logic [15:0] cfg_tdata;
   logic        cfg_tvalid, cfg_tready;
   logic [31:0] core_in_tdata;
   logic        core_in_tvalid, core_in_tready, core_in_tlast;
   logic [63:0] core_out_tdata;
   logic        core_out_tvalid, core_out_tready, core_out_tlast;
   logic        ev_tlast_unexpected, ev_tlast_missing;
   logic [31:0] out_re, out_im;
   logic [9:0]  out_idx;
   logic        out_valid, out_ready, out_last;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   fft_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inv(inv), .nfft_log2(nfft_log2),
      .err_clr(err_clr), .busy(busy), .frame_done(frame_done), .err(err),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
      .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid),
      .core_in_tready(core_in_tready), .core_in_tlast(core_in_tlast),
      .core_out_tdata(core_out_tdata), .core_out_tvalid(core_out_tvalid),
      .core_out_tready(core_out_tready), .core_out_tlast(core_out_tlast),
      .ev_tlast_unexpected(ev_tlast_unexpected), .ev_tlast_missing(ev_tlast_missing),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [4:0] l2, input logic iv, input logic exp_cfg,
                           input logic [15:0] exp_word, input int cfg_delay);
      int beats;
      nfft_log2  = l2;
      inv        = iv;
      cfg_tready = (cfg_delay == 0);
      start      = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", 64'(busy), 64'(1));
      chk("start_state", 64'(dbg_state), 64'(S_CFG));
      chk("start_cfg_valid", 64'(cfg_tvalid), 64'(exp_cfg));
      if (exp_cfg) chk("start_cfg_data", 64'(cfg_tdata), 64'(exp_word));
      for (int c = 0; c < cfg_delay; c++) begin
         step();
         chk("cfg_hold_state", 64'(dbg_state), 64'(S_CFG));
         chk("cfg_hold_valid", 64'(cfg_tvalid), 64'(1));
         chk("cfg_hold_data", 64'(cfg_tdata), 64'(exp_word));
      end
      cfg_tready = 1'b1;
      beats = (cfg_tvalid && cfg_tready) ? 1 : 0;
      step();
      chk("cfg_beats", 64'(beats), 64'(exp_cfg));
      chk("stream_entry", 64'(dbg_state), 64'(S_STREAM));
      chk("cfg_valid_off", 64'(cfg_tvalid), 64'(0));
   endtask

   // Push n_hs samples of a frame of length n_frame; gappy adds input and core stalls.
   task automatic send_inputs(input int n_hs, input int n_frame, input bit gappy);
      int hs = 0;
      int cyc = 0;
      logic [15:0] re_s, im_s;
      while (hs < n_hs && cyc < 400) begin
         in_tvalid      = gappy ? (cyc % 3 != 2) : 1'b1;
         core_in_tready = gappy ? (cyc % 2 == 0) : 1'b1;
         re_s = 16'h0A00 + 16'(hs);
         im_s = 16'hF000 - 16'(hs * 3);
         in_tdata = {im_s, re_s};
         #1;
         chk("in_data", 64'(core_in_tdata), 64'({im_s, re_s}));
         chk("in_valid", 64'(core_in_tvalid), 64'(in_tvalid));
         chk("in_ready", 64'(in_tready), 64'(core_in_tready));
         chk("in_tlast", 64'(core_in_tlast), 64'(hs == n_frame - 1));
         chk("no_cfg_in_stream", 64'(cfg_tvalid), 64'(0));
         if (in_tvalid && core_in_tready) hs++;
         cyc++;
         step();
      end
      in_tvalid = 1'b0;
      if (hs < n_hs) begin
         errors++;
         $display("FAIL input_timeout: got %0d handshakes expected %0d", hs, n_hs);
      end
   endtask

   task automatic after_stream_checks();
      in_tvalid      = 1'b1;
      core_in_tready = 1'b1;
      #1;
      chk("drain_state", 64'(dbg_state), 64'(S_DRAIN));
      chk("drain_in_ready", 64'(in_tready), 64'(0));
      chk("drain_core_valid", 64'(core_in_tvalid), 64'(0));
      chk("drain_tlast", 64'(core_in_tlast), 64'(0));
      in_tvalid = 1'b0;
   endtask

   // ---------------- output scoreboard ----------------
   task automatic recv_outputs(input int n_beats, input int tlast_at, input int stall_at,
                               input logic exp_err3);
      int idx = 0;
      int dones = 0;
      logic [31:0] re_v, im_v;
      logic [31:0] exp_q[$];
      for (int i = 0; i < n_beats; i++) exp_q.push_back(32'(i < tlast_at ? i : i - tlast_at));
      for (int i = 0; i < n_beats; i++) begin
         re_v = 32'hA000_0000 + 32'(i);
         im_v = 32'h5000_0000 - 32'(i * 7);
         core_out_tdata  = {im_v, re_v};
         core_out_tvalid = 1'b1;
         core_out_tlast  = (i == tlast_at - 1);
         if (i == stall_at) begin
            out_ready = 1'b0;
            #1;
            chk("out_stall_ready", 64'(core_out_tready), 64'(0));
            chk("out_stall_idx", 64'(out_idx), 64'(idx));
            step();
         end
         out_ready = 1'b1;
         #1;
         chk("out_re", 64'(out_re), 64'(re_v));
         chk("out_im", 64'(out_im), 64'(im_v));
         chk("out_valid", 64'(out_valid), 64'(1));
         chk("out_last", 64'(out_last), 64'(i == tlast_at - 1));
         chk("out_core_ready", 64'(core_out_tready), 64'(1));
         chk("out_idx", 64'(out_idx), 64'(exp_q.pop_front()));
         step();
         idx = core_out_tlast ? 0 : idx + 1;
         if (frame_done) dones++;
      end
      core_out_tvalid = 1'b0;
      core_out_tlast  = 1'b0;
      out_ready       = 1'b0;
      chk("done_pulse_count", 64'(dones), 64'(1));
      chk("done_busy", 64'(busy), 64'(0));
      chk("done_state", 64'(dbg_state), 64'(S_IDLE));
      chk("idx_wrap", 64'(out_idx), 64'(0));
      chk("err3", 64'(err[3]), 64'(exp_err3));
      step();
      chk("done_one_cycle", 64'(frame_done), 64'(0));
   endtask

   // ---------------- start/length vector table ----------------
   typedef struct {
      logic [4:0]  l2;
      logic        iv;
      logic        e_busy;
      logic        e_err0;
      logic        e_cfgv;
      logic [15:0] e_cfgd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[1] = '{5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[2] = '{5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 16'h0103};
      vecs[3] = '{5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h000A};
      vecs[4] = '{5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[5] = '{5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[6] = '{5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0007};

      rst_n = 1'b0; start = 1'b0; inv = 1'b0; nfft_log2 = 5'd4; err_clr = 1'b0;
      in_tdata = 32'h1234_5678; in_tvalid = 1'b1; core_in_tready = 1'b1;
      cfg_tready = 1'b0; core_out_tdata = '0; core_out_tvalid = 1'b0;
      core_out_tlast = 1'b0; out_ready = 1'b0;
      ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(frame_done), 64'(0));
      chk("rst_cfg_valid", 64'(cfg_tvalid), 64'(0));
      chk("rst_cfg_data", 64'(cfg_tdata), 64'(0));
      chk("rst_core_valid", 64'(core_in_tvalid), 64'(0));
      chk("rst_in_ready", 64'(in_tready), 64'(0));
      chk("rst_tlast", 64'(core_in_tlast), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_idx", 64'(out_idx), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
      rst_n = 1'b1;
      in_tvalid = 1'b0;
      step();

      for (int v = 0; v < 7; v++) begin
         nfft_log2 = vecs[v].l2;
         inv       = vecs[v].iv;
         start     = 1'b1;
         step();
         start = 1'b0;
         chk("tbl_busy", 64'(busy), 64'(vecs[v].e_busy));
         chk("tbl_err0", 64'(err[0]), 64'(vecs[v].e_err0));
         chk("tbl_cfg_valid", 64'(cfg_tvalid), 64'(vecs[v].e_cfgv));
         chk("tbl_cfg_data", 64'(cfg_tdata), 64'(vecs[v].e_cfgd));
         rst_n = 1'b0;
         step();
         rst_n = 1'b1;
         step();
      end

      // Basic frame: N=16 forward
      do_start(5'd4, 1'b0, 1'b1, 16'h0104, 0);
      send_inputs(16, 16, 1'b0);
      after_stream_checks();
      recv_outputs(16, 16, 5, 1'b0);
      chk("basic_err", 64'(err), 64'(0));

      // Same parameters: config skipped, gappy input
      do_start(5'd4, 1'b0, 1'b0, 16'h0104, 0);
      send_inputs(16, 16, 1'b1);
      after_stream_checks();
      recv_outputs(16, 16, -1, 1'b0);

      // Inverse: new config beat held through cfg_tready stall; early output tlast
      do_start(5'd4, 1'b1, 1'b1, 16'h0004, 3);
      send_inputs(16, 16, 1'b0);
      after_stream_checks();
      recv_outputs(8, 8, 2, 1'b1);

      // Illegal length and error clearing
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_err3", 64'(err), 64'(0));
      nfft_log2 = 5'd2;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("illegal_err", 64'(err), 64'(4'b0001));
      chk("illegal_busy", 64'(busy), 64'(0));
      chk("illegal_state", 64'(dbg_state), 64'(S_IDLE));
      step();
      chk("illegal_busy_later", 64'(busy), 64'(0));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_err0", 64'(err), 64'(0));
      err_clr = 1'b1;
      ev_tlast_missing = 1'b1;
      step();
      err_clr = 1'b0;
      ev_tlast_missing = 1'b0;
      chk("clr_vs_missing", 64'(err), 64'(4'b0100));
      ev_tlast_unexpected = 1'b1;
      step();
      ev_tlast_unexpected = 1'b0;
      chk("unexpected_sticky", 64'(err), 64'(4'b0110));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_all", 64'(err), 64'(0));

      // Reset mid-frame, then an identical N=8 frame must still send its config
      do_start(5'd3, 1'b0, 1'b1, 16'h0103, 0);
      send_inputs(5, 8, 1'b0);
      ev_tlast_missing = 1'b1;
      step();
      ev_tlast_missing = 1'b0;
      chk("mid_state", 64'(dbg_state), 64'(S_STREAM));
      chk("mid_err", 64'(err), 64'(4'b0100));
      rst_n = 1'b0;
      in_tvalid = 1'b1;
      core_in_tready = 1'b1;
      step();
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(frame_done), 64'(0));
      chk("mrst_cfg_valid", 64'(cfg_tvalid), 64'(0));
      chk("mrst_cfg_data", 64'(cfg_tdata), 64'(0));
      chk("mrst_err", 64'(err), 64'(0));
      chk("mrst_in_ready", 64'(in_tready), 64'(0));
      chk("mrst_core_valid", 64'(core_in_tvalid), 64'(0));
      chk("mrst_tlast", 64'(core_in_tlast), 64'(0));
      chk("mrst_state", 64'(dbg_state), 64'(S_IDLE));
      rst_n = 1'b1;
      in_tvalid = 1'b0;
      step();
      do_start(5'd3, 1'b0, 1'b1, 16'h0103, 1);
      send_inputs(8, 8, 1'b1);
      after_stream_checks();
      recv_outputs(8, 8, 3, 1'b0);
      chk("final_err", 64'(err), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
